// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle MIPS sequencer owning the PC, the delay-slot state and the shared memory port.
module instr_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reg_write_dec,
  input  logic        mem_read_dec,
  input  logic        mem_write_dec,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_be,
  input  logic        avm_waitrequest,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [3:0]  avm_byteenable,
  output logic        ir_en,
  output logic        mdr_en,
  output logic        reg_we,
  output logic [31:0] pc,
  output logic        active,
  output logic [2:0]  state
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_delay_target;
  logic        r_delay_pending;

  logic        w_fetch;
  logic        w_exec;
  logic        w_mem_st;
  logic        w_wb;
  logic        w_mem_op;
  logic        w_store;
  logic        w_commit;
  logic        w_halt;
  logic [31:0] w_next_pc;
  state_t      w_after_commit;

  assign w_fetch  = r_state == S_FETCH;
  assign w_exec   = r_state == S_EXEC;
  assign w_mem_st = r_state == S_MEM;
  assign w_wb     = r_state == S_WB;
  assign w_mem_op = mem_read_dec | mem_write_dec;
  assign w_store  = mem_write_dec & ~mem_read_dec;

  // An instruction retires in EXEC (no memory), on an accepted store, or in WB after a load.
  assign w_commit = (w_exec & ~w_mem_op) | (w_mem_st & w_store & ~avm_waitrequest) | w_wb;
  assign w_next_pc = r_delay_pending ? r_delay_target : r_pc + 32'd4;
  assign w_halt = r_delay_pending && r_delay_target == 32'd0;
  assign w_after_commit = w_halt ? S_HALT : S_FETCH;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_pc            <= RESET_VECTOR;
      r_delay_pending <= 1'b0;
      r_delay_target  <= 32'd0;
    end else begin
      if (w_commit) begin
        r_pc            <= w_next_pc;
        r_delay_pending <= 1'b0;
      end
      // A redirect inside a delay slot is dropped; otherwise it arms the slot.
      if (w_exec && redirect && !r_delay_pending) begin
        r_delay_pending <= 1'b1;
        r_delay_target  <= redirect_target;
      end
      case (r_state)
        S_IDLE:  r_state <= S_FETCH;
        S_FETCH: r_state <= avm_waitrequest ? S_FETCH : S_EXEC;
        S_EXEC:  r_state <= w_mem_op ? S_MEM : w_after_commit;
        S_MEM:   r_state <= (avm_waitrequest || !w_mem_op) ? S_MEM :
                            mem_read_dec ? S_WB : w_after_commit;
        S_WB:    r_state <= w_after_commit;
        default: r_state <= S_HALT;
      endcase
    end
  end

  assign avm_read       = w_fetch | (w_mem_st & mem_read_dec);
  assign avm_write      = w_mem_st & w_store;
  assign avm_address    = w_fetch ? r_pc : w_mem_st ? data_addr : 32'd0;
  assign avm_byteenable = w_fetch ? 4'hF : w_mem_st ? data_be : 4'h0;
  assign ir_en          = w_fetch & ~avm_waitrequest;
  assign mdr_en         = w_mem_st & mem_read_dec & ~avm_waitrequest;
  assign reg_we         = (w_exec & ~w_mem_op & reg_write_dec) | w_wb;
  assign pc             = r_pc;
  assign active         = w_fetch | w_exec | w_mem_st | w_wb;
  assign state          = r_state;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: randomized cycle checks of instr_sequencer against an architectural PC/delay-slot model.
module tb_instr_sequencer;
  localparam logic [31:0] RV = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reg_write_dec = 1'b0, mem_read_dec = 1'b0, mem_write_dec = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_target = 32'd0, data_addr = 32'd0;
  logic [3:0]  data_be = 4'h0;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_address, pc;
  logic        avm_read, avm_write, ir_en, mdr_en, reg_we, active;
  logic [3:0]  avm_byteenable;
  logic [2:0]  state;

  instr_sequencer #(.RESET_VECTOR(RV)) dut (
    .clk(clk), .rst_n(rst_n), .reg_write_dec(reg_write_dec), .mem_read_dec(mem_read_dec),
    .mem_write_dec(mem_write_dec), .redirect(redirect), .redirect_target(redirect_target),
    .data_addr(data_addr), .data_be(data_be), .avm_waitrequest(avm_waitrequest),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_byteenable(avm_byteenable), .ir_en(ir_en), .mdr_en(mdr_en), .reg_we(reg_we),
    .pc(pc), .active(active), .state(state)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  logic [31:0] mpc, mtgt;
  logic mpend, mhalt;
  logic [76:0] obs, exp_v, msk, noab;

  assign obs = {state, avm_read, avm_write, avm_address, avm_byteenable, ir_en, mdr_en, reg_we, pc, active};

  function automatic logic [76:0] mk(input logic [2:0] st, input logic rd, input logic wr,
                                     input logic [31:0] ad, input logic [3:0] be, input logic ir,
                                     input logic mdr, input logic we, input logic [31:0] p, input logic act);
    return {st, rd, wr, ad, be, ir, mdr, we, p, act};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    exp_v = mk(3'd0, 1'b0, 1'b0, 32'd0, 4'h0, 1'b0, 1'b0, 1'b0, RV, 1'b0);
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL reset_hold: got %h want %h", obs, exp_v); end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL reset_idle: got %h want %h", obs, exp_v); end
    mpc = RV; mpend = 1'b0; mtgt = 32'd0; mhalt = 1'b0;
  endtask

  // Drives one instruction from FETCH to commit, checking every cycle, then advances the model.
  task automatic run_instr(input string nm, input logic rw, input logic mr, input logic mw,
                           input logic rd, input logic [31:0] tg, input logic [31:0] da,
                           input logic [3:0] be, input int wf, input int wm);
    logic mem_op = mr | mw;
    logic op = mpend;
    logic [31:0] p = mpc;
    for (int c = 0; c <= wf; c++) begin
      @(negedge clk);
      if (c == 0) begin
        reg_write_dec = rw; mem_read_dec = mr; mem_write_dec = mw;
        redirect = rd; redirect_target = tg; data_addr = da; data_be = be;
      end
      avm_waitrequest = c < wf;
      #1;
      exp_v = mk(3'd1, 1'b1, 1'b0, p, 4'hF, c == wf, 1'b0, 1'b0, p, 1'b1);
      vectors++;
      if (obs !== exp_v) begin miscompares++; $display("FAIL %s fetch%0d: got %h want %h", nm, c, obs, exp_v); end
    end
    @(negedge clk);
    avm_waitrequest = ($urandom & 1) != 0;
    #1;
    exp_v = mk(3'd2, 1'b0, 1'b0, 32'd0, 4'h0, 1'b0, 1'b0, !mem_op && rw, p, 1'b1);
    vectors++;
    if ((obs & noab) !== (exp_v & noab)) begin
      miscompares++; $display("FAIL %s exec: got %h want %h", nm, obs & noab, exp_v & noab);
    end
    if (mem_op) begin
      for (int c = 0; c <= wm; c++) begin
        @(negedge clk);
        avm_waitrequest = c < wm;
        #1;
        exp_v = mk(3'd3, mr, mw && !mr, da, be, 1'b0, mr && c == wm, 1'b0, p, 1'b1);
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL %s mem%0d: got %h want %h", nm, c, obs, exp_v); end
      end
    end
    if (mr) begin
      @(negedge clk);
      avm_waitrequest = ($urandom & 1) != 0;
      #1;
      exp_v = mk(3'd4, 1'b0, 1'b0, 32'd0, 4'h0, 1'b0, 1'b0, 1'b1, p, 1'b1);
      vectors++;
      if ((obs & noab) !== (exp_v & noab)) begin
        miscompares++; $display("FAIL %s wb: got %h want %h", nm, obs & noab, exp_v & noab);
      end
    end
    if (op) begin
      mhalt = mtgt == 32'd0; mpc = mtgt; mpend = 1'b0;
    end else begin
      mpc = mpc + 32'd4;
      if (rd) begin mpend = 1'b1; mtgt = tg; end
    end
  endtask

  task automatic test_alu();
    test_reset();
    run_instr("addu", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0, 4'h0, 0, 0);
    run_instr("nop_alu", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0, 4'h0, 0, 0);
  endtask

  task automatic test_fetch_wait();
    run_instr("fetch_wait3", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0, 4'h0, 3, 0);
  endtask

  task automatic test_load();
    test_reset();
    run_instr("lw", 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'h1000, 4'hF, 0, 0);
    run_instr("lw_wait", 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'h2004, 4'hC, 1, 2);
    run_instr("lw_and_sw", 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 32'h3000, 4'h1, 0, 1);
  endtask

  task automatic test_store();
    run_instr("sw", 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'h1000, 4'b0011, 0, 0);
    run_instr("sw_wait", 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'h4008, 4'b1100, 2, 3);
  endtask

  task automatic test_wrap();
    test_reset();
    run_instr("j_top", 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'h0, 4'h0, 0, 0);
    run_instr("slot_ign", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 4'h0, 0, 0);
    for (int i = 0; i < 3; i++) run_instr("wrap_alu", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0, 4'h0, 0, 0);
  endtask

  task automatic test_reset_mid_mem();
    test_reset();
    run_instr("j_pend", 1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_0000, 32'h0, 4'h0, 0, 0);
    @(negedge clk);
    reg_write_dec = 1'b1; mem_read_dec = 1'b1; mem_write_dec = 1'b0; redirect = 1'b0;
    data_addr = 32'h1000; data_be = 4'hF; avm_waitrequest = 1'b0;
    @(negedge clk);
    @(negedge clk);
    avm_waitrequest = 1'b1;
    #1;
    exp_v = mk(3'd3, 1'b1, 1'b0, 32'h1000, 4'hF, 1'b0, 1'b0, 1'b0, RV + 32'd4, 1'b1);
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL rst_mid_mem_pre: got %h want %h", obs, exp_v); end
    #2;
    rst_n = 1'b0;
    #1;
    exp_v = mk(3'd0, 1'b0, 1'b0, 32'd0, 4'h0, 1'b0, 1'b0, 1'b0, RV, 1'b0);
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL rst_mid_mem_async: got %h want %h", obs, exp_v); end
    @(negedge clk);
    rst_n = 1'b1;
    avm_waitrequest = 1'b0;
    mpc = RV; mpend = 1'b0; mtgt = 32'd0; mhalt = 1'b0;
    run_instr("post_rst_a", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0, 4'h0, 0, 0);
    run_instr("post_rst_b", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0, 4'h0, 0, 0);
  endtask

  task automatic test_random();
    test_reset();
    for (int i = 0; i < 150; i++) begin
      int k = $urandom_range(0, 4);
      logic mr = k == 1;
      logic mw = k == 2 || (k == 1 && ($urandom_range(0, 3) == 0));
      logic rd = k == 3 || (k == 0 && ($urandom_range(0, 3) == 0));
      logic [31:0] tg = $urandom & 32'hFFFF_FFFC;
      if (tg == 32'd0) tg = 32'd4;
      run_instr("rand", ($urandom & 1) != 0, mr, mw, rd, tg, $urandom, 4'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 2));
    end
  endtask

  task automatic test_halt();
    test_reset();
    run_instr("jr0", 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'h0, 4'h0, 0, 0);
    run_instr("slot_addu", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0, 4'h0, 1, 0);
    vectors++;
    if (mhalt !== 1'b1) begin miscompares++; $display("FAIL halt_model: got %b want 1", mhalt); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      reg_write_dec = ($urandom & 1) != 0; mem_read_dec = ($urandom & 1) != 0;
      mem_write_dec = ($urandom & 1) != 0; redirect = ($urandom & 1) != 0;
      avm_waitrequest = ($urandom & 1) != 0;
      #1;
      exp_v = mk(3'd5, 1'b0, 1'b0, 32'd0, 4'h0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      vectors++;
      if ((obs & noab) !== (exp_v & noab)) begin
        miscompares++; $display("FAIL halt%0d: got %h want %h", c, obs & noab, exp_v & noab);
      end
    end
  endtask

  initial begin
    noab = mk(3'h7, 1'b1, 1'b1, 32'h0, 4'h0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
    test_reset();
    test_alu();
    test_fetch_wait();
    test_load();
    test_store();
    test_wrap();
    test_reset_mid_mem();
    test_random();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle instruction sequencer for the MIPS core. It owns the PC and the branch-delay-slot state. It drives the single shared Avalon-style memory port for both instruction fetch and data access, and gates the decoder's RegWrite/MemRead/MemWrite/Jump results into one-cycle commit strobes. It sits between the combinational decoder, the register file and the memory bus, and it detects program termination (jump to address 0).

## Interface
Parameters:
- RESET_VECTOR, 32'hBFC0_0000, PC value loaded at reset.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- reg_write_dec  in  1  decoder RegWrite.
- mem_read_dec  in  1  decoder MemRead (load).
- mem_write_dec  in  1  decoder MemWrite (store).
- redirect  in  1  current instruction is a taken branch/jump (sampled in EXEC only).
- redirect_target  in  32  target for redirect.
- data_addr  in  32  effective address from ALU, valid in EXEC/MEM.
- data_be  in  4  byte enables for data access.
- avm_waitrequest  in  1  bus stall.
- avm_address  out  32  bus address.
- avm_read  out  1  bus read request.
- avm_write  out  1  bus write request.
- avm_byteenable  out  4  bus byte enables.
- ir_en  out  1  latch avm_readdata into the instruction register this cycle.
- mdr_en  out  1  latch avm_readdata into the load data register this cycle.
- reg_we  out  1  register-file write strobe.
- pc  out  32  current instruction address.
- active  out  1  high while executing; low in IDLE and HALT.
- state  out  3  IDLE=0, FETCH=1, EXEC=2, MEM=3, WB=4, HALT=5.

## Operation
- States:
  - IDLE → FETCH unconditionally.
  - FETCH: avm_read=1, avm_address=pc, byteenable=4'hF. Stays while avm_waitrequest=1. On accept (read & !waitrequest), ir_en=1 → EXEC.
  - EXEC: decoder outputs are valid.
    - If mem_read_dec or mem_write_dec → MEM.
    - Else commit; reg_we=reg_write_dec → FETCH.
    - redirect sampled here.
  - MEM: avm_address=data_addr, byteenable=data_be. avm_read=mem_read_dec, avm_write=mem_write_dec & !mem_read_dec (read wins if both set). Stays while waitrequest.
    - Accepted load: mdr_en=1 → WB.
    - Accepted store: commit → FETCH.
  - WB: reg_we=1, commit → FETCH.
  - HALT: absorbing until reset. No bus activity; reg_we=0.
- Delay slot: internal delay_pending (1b) and delay_target (32b).
  - In EXEC, redirect=1 with delay_pending=0 sets delay_target=redirect_target and delay_pending=1.
  - redirect in a delay-slot instruction (delay_pending=1) is ignored.
- Commit (the last cycle of an instruction):
  - If delay_pending: pc←delay_target, delay_pending←0. If delay_target==0, next state is HALT instead of FETCH.
  - Else pc←pc+4 (mod 2^32, wraps silently).
- reg_we is asserted in exactly one cycle per register-writing instruction, never in FETCH/MEM/IDLE/HALT.
- Outputs are combinational from state plus the inputs listed above. avm_read and avm_write are never both 1.

## Timing
- Reset (asynchronous, any time including mid-bus-transaction): state=IDLE, pc=RESET_VECTOR, delay_pending=0, delay_target=0. All strobes (avm_read, avm_write, ir_en, mdr_en, reg_we) =0, avm_address=0, avm_byteenable=0, active=0. An in-flight bus request is abandoned.
- First FETCH occurs on the first rising edge after rst_n deasserts.
- Zero-wait latency: ALU/jump = 2 cycles (FETCH, EXEC); store = 3; load = 4.
- Each waitrequest cycle adds exactly one cycle. Address, byteenable and read/write stay stable while waitrequest=1.
- pc changes only on the commit edge; it holds during the instruction.
- active=1 in FETCH/EXEC/MEM/WB. active falls on the edge entering HALT, after the delay-slot instruction has committed.

## Test plan
- Reset then zero-wait bus, memory returns ADDU at 0xBFC00000: IDLE 1 cycle, FETCH addr 0xBFC00000, EXEC reg_we=1, pc=0xBFC00004 after cycle 3.
- FETCH with waitrequest high 3 cycles: avm_read/address held 4 cycles, ir_en only in 4th, total instruction 5 cycles.
- LW at 0xBFC00000, data_addr=0x1000, data_be=4'hF: MEM read addr 0x1000, mdr_en, WB reg_we=1, reg_we pulses exactly once.
- SW, data_be=4'b0011: avm_write=1 addr data_addr byteenable 0011, reg_we never asserted, 3 cycles.
- JR to 0x0 followed by ADDU in slot: slot fetched from pc+4 and commits reg_we, then state=HALT, pc=0, active=0, no further bus requests for 20 cycles.
- rst_n pulsed low during MEM with waitrequest=1: outputs drop immediately to reset values, restart at RESET_VECTOR, delay_pending cleared.
